// File: rtl/round_ctrl_if.sv
// Control/status bundle between the snake game round sequencer and its
// surroundings: tick/button/game inputs in, timer control and BCD display out.
`timescale 1ns/1ps
interface round_ctrl_if;
  logic       en100hz;
  logic       start_btn;
  logic       pause_btn;
  logic       eat;
  logic       time_up;
  logic       timer_run;
  logic       timer_clear;
  logic [3:0] score_h;
  logic [3:0] score_l;
  logic [3:0] best_h;
  logic [3:0] best_l;
  logic [1:0] ready_cnt;
  logic [1:0] disp_mode;
  logic [2:0] state;
  logic       game_over;

  modport master (
    output en100hz, start_btn, pause_btn, eat, time_up,
    input  timer_run, timer_clear, score_h, score_l, best_h, best_l,
           ready_cnt, disp_mode, state, game_over
  );

  modport slave (
    input  en100hz, start_btn, pause_btn, eat, time_up,
    output timer_run, timer_clear, score_h, score_l, best_h, best_l,
           ready_cnt, disp_mode, state, game_over
  );
endinterface

// File: rtl/round_ctrl.sv
// Snake round sequencer: IDLE -> READY countdown -> PLAY/PAUSE -> OVER, owning BCD
// score/best. Define ROUND_BEST_SCORE_EN to build the best-score register and display.
`timescale 1ns/1ps
module round_ctrl #(
  parameter int READY_SEC     = 3,
  parameter int TICKS_PER_SEC = 100,
  parameter int SCORE_MAX     = 99
) (
  input  logic         CLK1_50,
  input  logic         CLR,
  round_ctrl_if.slave  bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam int         SW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);
  localparam logic [1:0] READY_INIT = 2'(READY_SEC);
  localparam logic [7:0] SCORE_TOP  = {4'(SCORE_MAX / 10), 4'(SCORE_MAX % 10)};

  logic [2:0]    state;
  logic [2:0]    start_sy, pause_sy;
  logic          start_p, pause_p;
  logic [SW-1:0] sec_cnt;
  logic [1:0]    ready_cnt, disp_mode;
  logic          timer_run, timer_clear;
  logic [7:0]    score, score_inc, score_fin, best;
  logic          sec_wrap;

  // Two sync flops plus one history flop; the press pulse is registered,
  // so it is seen by the FSM three edges after the button rises.
  always_ff @(posedge CLK1_50 or negedge CLR) begin
    if (!CLR) begin
      start_sy <= '0;
      pause_sy <= '0;
      start_p  <= 1'b0;
      pause_p  <= 1'b0;
    end else begin
      start_sy <= {start_sy[1:0], bus.start_btn};
      pause_sy <= {pause_sy[1:0], bus.pause_btn};
      start_p  <= start_sy[1] & ~start_sy[2];
      pause_p  <= pause_sy[1] & ~pause_sy[2];
    end
  end

  assign score_inc = (score == SCORE_TOP) ? score :
                     (score[3:0] == 4'd9) ? {score[7:4] + 4'd1, 4'd0} :
                                            {score[7:4], score[3:0] + 4'd1};
  assign score_fin = bus.eat ? score_inc : score;
  assign sec_wrap  = bus.en100hz && (sec_cnt == SEC_LAST);

  always_ff @(posedge CLK1_50 or negedge CLR) begin
    if (!CLR) begin
      state       <= IDLE;
      sec_cnt     <= '0;
      ready_cnt   <= '0;
      disp_mode   <= '0;
      timer_run   <= 1'b0;
      timer_clear <= 1'b0;
      score       <= '0;
    end else begin
      timer_run   <= (state == PLAY);
      timer_clear <= 1'b0;
      case (state)
        IDLE: begin
          disp_mode <= 2'd0;
          if (start_p) begin
            state       <= READY;
            timer_clear <= 1'b1;
            score       <= '0;
            ready_cnt   <= READY_INIT;
            sec_cnt     <= '0;
            disp_mode   <= 2'd1;
          end
        end
        READY: begin
          if (bus.en100hz) begin
            if (sec_wrap) begin
              sec_cnt <= '0;
              if (ready_cnt == 2'd1) begin
                state     <= PLAY;
                ready_cnt <= 2'd0;
                disp_mode <= 2'd0;
              end else begin
                ready_cnt <= ready_cnt - 2'd1;
              end
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        PLAY: begin
          score <= score_fin;
          if (bus.time_up) begin
            state     <= OVER;
            sec_cnt   <= '0;
            disp_mode <= 2'd2;
          end else if (pause_p) begin
            state   <= PAUSE;
            sec_cnt <= '0;
          end
        end
        PAUSE: begin
          if (bus.time_up) begin
            state     <= OVER;
            sec_cnt   <= '0;
            disp_mode <= 2'd2;
          end else if (start_p) begin
            state     <= IDLE;
            score     <= '0;
            sec_cnt   <= '0;
            disp_mode <= 2'd0;
          end else if (pause_p) begin
            state   <= PLAY;
            sec_cnt <= '0;
          end
        end
        OVER: begin
          if (start_p) begin
            state       <= READY;
            timer_clear <= 1'b1;
            score       <= '0;
            ready_cnt   <= READY_INIT;
            sec_cnt     <= '0;
            disp_mode   <= 2'd1;
          end else if (bus.en100hz) begin
            if (sec_wrap) begin
              sec_cnt <= '0;
`ifdef ROUND_BEST_SCORE_EN
              disp_mode <= (disp_mode == 2'd2) ? 2'd3 : 2'd2;
`endif
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUND_BEST_SCORE_EN
  logic       over_entry;
  logic [7:0] final_score;

  // BCD digits order the same as their binary packing, so a plain compare works.
  assign over_entry  = ((state == PLAY) || (state == PAUSE)) && bus.time_up;
  assign final_score = (state == PLAY) ? score_fin : score;

  always_ff @(posedge CLK1_50 or negedge CLR) begin
    if (!CLR)
      best <= '0;
    else if (over_entry && (final_score > best))
      best <= final_score;
  end
`else
  assign best = 8'd0;
`endif

  assign bus.state       = state;
  assign bus.timer_run   = timer_run;
  assign bus.timer_clear = timer_clear;
  assign bus.score_h     = score[7:4];
  assign bus.score_l     = score[3:0];
  assign bus.best_h      = best[7:4];
  assign bus.best_l      = best[3:0];
  assign bus.ready_cnt   = ready_cnt;
  assign bus.disp_mode   = disp_mode;
  assign bus.game_over   = (state == OVER);
endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: scoreboarded status snapshots, an eat-count
// table, and hand-written sequences for pause, end-of-round and reset corners.
`timescale 1ns/1ps
module tb_round_ctrl;
`ifdef ROUND_BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  round_ctrl_if bus();
  round_ctrl dut (.CLK1_50(clk), .CLR(clr), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int n_clr_pulse = 0;

  always @(negedge clk) if (bus.timer_clear === 1'b1) n_clr_pulse++;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [7:0] score;
    logic [7:0] best;
    logic [1:0] rdy;
    logic [1:0] disp;
    logic       run;
    bit         chk_disp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         n;
    logic [7:0] score;
  } eat_vec_t;
  eat_vec_t eat_tab[7];

  function automatic logic [7:0] bx(input logic [7:0] v);
    return BEST_EN ? v : 8'h00;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Snapshot expectation goes into the scoreboard; the next negedge sample retires it.
  task automatic expect_out(input string name, input logic [2:0] st, input logic [7:0] sc,
                            input logic [7:0] bs, input logic [1:0] rdy, input logic [1:0] disp,
                            input logic run, input bit cd = 1'b1);
    exp_t e;
    e.name = name; e.st = st; e.score = sc; e.best = bs;
    e.rdy = rdy; e.disp = disp; e.run = run; e.chk_disp = cd;
    sb.push_back(e);
    pop_check();
  endtask

  task automatic pop_check();
    exp_t e;
    logic [7:0] a_sc, a_bs;
    bit ok;
    @(negedge clk);
    e = sb.pop_front();
    a_sc = {bus.score_h, bus.score_l};
    a_bs = {bus.best_h, bus.best_l};
    ok = (bus.state === e.st) && (a_sc === e.score) && (a_bs === e.best) &&
         (bus.ready_cnt === e.rdy) && (bus.timer_run === e.run) &&
         (bus.game_over === (e.st == 3'd4)) && (!e.chk_disp || bus.disp_mode === e.disp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got st=%0d sc=%h best=%h rdy=%0d disp=%0d run=%b go=%b, want st=%0d sc=%h best=%h rdy=%0d disp=%0d run=%b",
               e.name, bus.state, a_sc, a_bs, bus.ready_cnt, bus.disp_mode, bus.timer_run, bus.game_over,
               e.st, e.score, e.best, e.rdy, e.disp, e.run);
    end
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1; cyc(6); bus.start_btn = 1'b0; cyc(3);
  endtask

  task automatic press_pause();
    bus.pause_btn = 1'b1; cyc(6); bus.pause_btn = 1'b0; cyc(3);
  endtask

  task automatic ticks(input int n);
    bus.en100hz = 1'b1; cyc(n); bus.en100hz = 1'b0; cyc(1);
  endtask

  task automatic eat_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.eat = 1'b1; cyc(1); bus.eat = 1'b0; cyc(1);
    end
  endtask

  task automatic apply_eat(input int idx);
    eat_n(eat_tab[idx].n);
    expect_out($sformatf("eat_tab%0d", idx), 3'd2, eat_tab[idx].score, 8'h00, 2'd0, 2'd0, 1'b1, 1'b1);
  endtask

  task automatic ready_to_play(input logic [7:0] bs);
    ticks(300);
    expect_out("ready_to_play", 3'd2, 8'h00, bs, 2'd0, 2'd0, 1'b1);
  endtask

  initial begin
    eat_tab[0] = '{12, 8'h12};
    eat_tab[1] = '{11, 8'h23};
    eat_tab[2] = '{7,  8'h07};
    eat_tab[3] = '{5,  8'h05};
    eat_tab[4] = '{40, 8'h40};
    eat_tab[5] = '{59, 8'h99};
    eat_tab[6] = '{1,  8'h99};

    bus.en100hz = 0; bus.start_btn = 0; bus.pause_btn = 0; bus.eat = 0; bus.time_up = 0;
    cyc(3);
    expect_out("reset", 3'd0, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0);
    clr = 1'b1;
    cyc(2);

    // Round 1: countdown boundaries, counting, pause.
    press_start();
    expect_out("ready_entry", 3'd1, 8'h00, 8'h00, 2'd3, 2'd1, 1'b0);
    chk("clear_pulse_1", n_clr_pulse, 1);
    ticks(100);
    expect_out("ready_2", 3'd1, 8'h00, 8'h00, 2'd2, 2'd1, 1'b0);
    ticks(100);
    expect_out("ready_1", 3'd1, 8'h00, 8'h00, 2'd1, 2'd1, 1'b0);
    ticks(99);
    expect_out("ready_299", 3'd1, 8'h00, 8'h00, 2'd1, 2'd1, 1'b0);
    ticks(1);
    expect_out("play_entry", 3'd2, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1);
    apply_eat(0);
    press_pause();
    expect_out("pause_entry", 3'd3, 8'h12, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
    eat_n(3);
    ticks(150);
    expect_out("pause_eat_ign", 3'd3, 8'h12, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
    press_pause();
    expect_out("pause_resume", 3'd2, 8'h12, 8'h00, 2'd0, 2'd0, 1'b1);
    apply_eat(1);

    // Asynchronous reset mid-PLAY, then a start held across reset release.
    clr = 1'b0;
    #1;
    chk("clr_state", bus.state, 0);
    chk("clr_score", {bus.score_h, bus.score_l}, 0);
    chk("clr_best", {bus.best_h, bus.best_l}, 0);
    chk("clr_run", bus.timer_run, 0);
    bus.start_btn = 1'b1; cyc(2);
    clr = 1'b1; cyc(10);
    bus.start_btn = 1'b0; cyc(3);
    expect_out("held_start", 3'd1, 8'h00, 8'h00, 2'd3, 2'd1, 1'b0);
    chk("clear_pulse_2", n_clr_pulse, 2);

    // Round 2: eat and time_up together.
    ready_to_play(8'h00);
    apply_eat(2);
    bus.eat = 1'b1; bus.time_up = 1'b1; cyc(1);
    bus.eat = 1'b0; bus.time_up = 1'b0; cyc(2);
    expect_out("over_eat_tu", 3'd4, 8'h08, bx(8'h08), 2'd0, 2'd2, 1'b0);
    ticks(100);
    expect_out("over_disp_1", 3'd4, 8'h08, bx(8'h08), 2'd0, BEST_EN ? 2'd3 : 2'd2, 1'b0);
    ticks(100);
    expect_out("over_disp_2", 3'd4, 8'h08, bx(8'h08), 2'd0, 2'd2, 1'b0);

    // Round 3: lower score keeps best.
    press_start();
    expect_out("restart", 3'd1, 8'h00, bx(8'h08), 2'd3, 2'd1, 1'b0);
    chk("clear_pulse_3", n_clr_pulse, 3);
    ready_to_play(bx(8'h08));
    eat_n(eat_tab[3].n);
    expect_out("eat_tab3", 3'd2, eat_tab[3].score, bx(8'h08), 2'd0, 2'd0, 1'b1);
    bus.time_up = 1'b1; cyc(1); bus.time_up = 1'b0; cyc(2);
    expect_out("over_low", 3'd4, 8'h05, bx(8'h08), 2'd0, 2'd2, 1'b0);

    // Round 4: saturation, then time_up while paused.
    press_start();
    chk("clear_pulse_4", n_clr_pulse, 4);
    ready_to_play(bx(8'h08));
    for (int i = 4; i < 7; i++) begin
      eat_n(eat_tab[i].n);
      expect_out($sformatf("eat_tab%0d", i), 3'd2, eat_tab[i].score, bx(8'h08), 2'd0, 2'd0, 1'b1);
    end
    press_pause();
    expect_out("pause_99", 3'd3, 8'h99, bx(8'h08), 2'd0, 2'd0, 1'b0, 1'b0);
    bus.time_up = 1'b1; cyc(1); bus.time_up = 1'b0; cyc(2);
    expect_out("over_from_pause", 3'd4, 8'h99, bx(8'h99), 2'd0, 2'd2, 1'b0);
    chk("clear_pulse_total", n_clr_pulse, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
- Game-round sequencer for the snake timer/score datapath.
- Runs the round sequence: ready countdown, 30 s timed play, pause, then game-over with score and best-score display.
- Drives clear/run control of the 100 Hz stopwatch chain and the 7-seg display source select.
- Owns the BCD score and best-score registers.

Parameters:
READY_SEC, 3, ready countdown length in seconds (1..3)
TICKS_PER_SEC, 100, en100hz ticks per second
SCORE_MAX, 99, saturation value of the BCD score (<=99)

Ports:
CLK1_50  in  1  system clock
CLR  in  1  asynchronous active-low reset
en100hz  in  1  one-cycle 100 Hz tick enable
start_btn  in  1  raw start button, active-high, asynchronous
pause_btn  in  1  raw pause button, active-high, asynchronous
eat  in  1  one-cycle score-increment pulse from game logic
time_up  in  1  level, high when the 30 s timer has expired
timer_run  out  1  timer count enable, high only in PLAY
timer_clear  out  1  one-cycle timer clear pulse
score_h  out  4  score tens (BCD)
score_l  out  4  score units (BCD)
best_h  out  4  best-score tens (BCD)
best_l  out  4  best-score units (BCD)
ready_cnt  out  2  remaining ready seconds
disp_mode  out  2  0 time, 1 ready countdown, 2 score, 3 best
state  out  3  current FSM state
game_over  out  1  high in OVER

Behaviour:
- Reset (CLR=0, async): state=IDLE; all outputs 0 except disp_mode=0; synchronizers cleared.
- Buttons: each passes a 2-FF synchronizer, then a rising-edge detector.
  - Press = one-cycle pulse, 3 cycles after the input rises.
  - Holding a button produces no repeats.
- States: IDLE=0, READY=1, PLAY=2, PAUSE=3, OVER=4.
- IDLE:
  - disp_mode=0.
  - start press -> READY; timer_clear pulses that cycle; score cleared to 00.
- READY:
  - ready_cnt loads READY_SEC on entry; sec_cnt counts en100hz ticks.
  - Every TICKS_PER_SEC ticks, ready_cnt decrements.
  - When ready_cnt would go 1->0 -> PLAY.
  - disp_mode=1.
  - pause and eat ignored.
- PLAY:
  - timer_run=1; disp_mode=0.
  - eat increments score in BCD: units wrap 9->0 with tens carry; saturates at SCORE_MAX.
  - pause press -> PAUSE.
  - time_up=1 -> OVER.
  - eat and time_up in the same cycle: the eat is counted, then -> OVER.
  - pause press and time_up in the same cycle: OVER wins.
- PAUSE:
  - timer_run=0; sec_cnt frozen; eat ignored.
  - pause press -> PLAY.
  - start press -> IDLE with score cleared.
  - time_up=1 -> OVER.
- OVER:
  - game_over=1; timer_run=0.
  - On entry, if score > best then best <= score; the comparison uses the final score including a same-cycle eat.
  - disp_mode alternates 2/3 every TICKS_PER_SEC ticks, starting at 2.
  - start press -> READY with timer_clear pulse and score clear; best is retained.
- Timing: timer_run changes on the clock edge after the state change (registered output).
- timer_clear is only ever asserted on the IDLE->READY and OVER->READY edges.
- sec_cnt resets to 0 on every state entry.
- en100hz is ignored outside READY and OVER.
- Best score is cleared only by CLR.

Optional Feature:
ROUND_BEST_SCORE_EN
- Defined: best registers and OVER score/best alternation as above.
- Undefined: best_h/best_l tied to 0; OVER holds disp_mode=2 permanently; no comparator or best registers synthesised.

Test Plan:
- Reset, then start press -> timer_clear high 1 cycle; READY with ready_cnt 3,2,1 at 100-tick intervals; PLAY after 300 ticks; timer_run=1.
- In PLAY, 12 eat pulses -> score_h=1, score_l=2; 100 total eat pulses -> score saturates at 9/9.
- In PLAY: pause press -> timer_run=0 next cycle; eat pulses ignored; pause press again -> PLAY resumes with score unchanged.
- eat and time_up in the same cycle at score 07 -> OVER with score 08 and best 08; disp_mode toggles 2,3,2 at 100-tick spacing.
- Second round ending at score 05 -> best stays 08; start in OVER -> score 00, best 08, timer_clear pulse.
- Assert CLR mid-PLAY with score 23 -> immediately IDLE, score 00, best 00, timer_run 0; held start button after release of CLR yields a single press only.
